// File: rtl/str_serializer.sv
// ---------------------------------------------------------------------------
// str_serializer
//
// Captures a packed ASCII digit string on a one-cycle load strobe and sends
// it one byte per transfer, most significant character first, over a
// valid/ready byte handshake. It can optionally skip leading '0' characters
// and append a CR/LF terminator.
//
// Parameters:
//   pChars      : number of characters in iString (>= 1)
//   pBlankZeros : 1 = skip leading 8'h30 characters (the last one is always sent)
//   pAppendCRLF : 1 = send 8'h0D, 8'h0A after the last character
//
// Ports:
//   iClock     in   rising-edge clock
//   iReset_n   in   asynchronous active-low reset
//   iString    in   packed characters, char k at [8k+7:8k], k=pChars-1 is MS
//   iLoad      in   capture strobe (converter done)
//   oByte      out  current byte, held while stalled
//   oValid     out  oByte is valid
//   iReady     in   consumer accepts; transfer = oValid & iReady
//   oBusy      out  frame in progress
//   oFrameDone out  one-cycle pulse in the first idle cycle after a frame
//   oDropped   out  one-cycle pulse after an iLoad that arrived while busy
// ---------------------------------------------------------------------------
module str_serializer #(
  parameter int pChars      = 4,
  parameter bit pBlankZeros = 1'b1,
  parameter bit pAppendCRLF = 1'b1
) (
  input  logic                  iClock,
  input  logic                  iReset_n,
  input  logic [8*pChars-1:0]   iString,
  input  logic                  iLoad,
  output logic [7:0]            oByte,
  output logic                  oValid,
  input  logic                  iReady,
  output logic                  oBusy,
  output logic                  oFrameDone,
  output logic                  oDropped
);

  // A single-character string still needs a 1-bit index register.
  localparam int IdxW = (pChars > 1) ? $clog2(pChars) : 1;

  localparam logic [7:0] AsciiZero = 8'h30;
  localparam logic [7:0] AsciiCr   = 8'h0D;
  localparam logic [7:0] AsciiLf   = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    CHAR,
    CR,
    LF
  } state_t;

  state_t              state;
  logic [8*pChars-1:0] latched;
  logic [IdxW-1:0]     index;

  logic [IdxW-1:0]     start_index;
  logic [7:0]          start_char;
  logic [IdxW-1:0]     next_index;
  logic [7:0]          next_char;
  logic                xfer;

  assign xfer       = oValid & iReady;
  assign next_index = index - 1'b1;

  // oValid is registered and is high exactly when the FSM is outside IDLE,
  // so busy is derived from the same state register.
  assign oBusy = (state != IDLE);

  // Start-index priority encoder: the highest non-'0' character wins, or
  // index 0 when every character is '0'. Scanning upward and letting later
  // hits overwrite earlier ones gives highest-index priority.
  always_comb begin
    start_index = '0;
    if (!pBlankZeros) begin
      start_index = IdxW'(pChars - 1);
    end else begin
      for (int k = 0; k < pChars; k++) begin
        if (iString[8*k +: 8] != AsciiZero) begin
          start_index = IdxW'(k);
        end
      end
    end
  end

  // Character selection muxes: the first byte comes straight from iString so
  // it can be registered on the load edge; later bytes come from the latched
  // copy at index-1 so they are ready on the transfer edge.
  always_comb begin
    start_char = '0;
    next_char  = '0;
    for (int k = 0; k < pChars; k++) begin
      if (start_index == IdxW'(k)) begin
        start_char = iString[8*k +: 8];
      end
      if (next_index == IdxW'(k)) begin
        next_char = latched[8*k +: 8];
      end
    end
  end

  // Main FSM. All outputs are registered here so oByte/oValid never depend
  // combinationally on iReady. Each state preloads the byte for the state it
  // moves to, which gives one byte per cycle with no bubbles.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state      <= IDLE;
      latched    <= '0;
      index      <= '0;
      oByte      <= '0;
      oValid     <= 1'b0;
      oFrameDone <= 1'b0;
      oDropped   <= 1'b0;
    end else begin
      oFrameDone <= 1'b0;
      oDropped   <= iLoad && (state != IDLE);

      case (state)
        IDLE: begin
          if (iLoad) begin
            latched <= iString;
            index   <= start_index;
            oByte   <= start_char;
            oValid  <= 1'b1;
            state   <= CHAR;
          end
        end

        CHAR: begin
          if (xfer) begin
            if (index != '0) begin
              index <= next_index;
              oByte <= next_char;
            end else if (pAppendCRLF) begin
              oByte <= AsciiCr;
              state <= CR;
            end else begin
              oByte      <= '0;
              oValid     <= 1'b0;
              oFrameDone <= 1'b1;
              state      <= IDLE;
            end
          end
        end

        CR: begin
          if (xfer) begin
            oByte <= AsciiLf;
            state <= LF;
          end
        end

        LF: begin
          if (xfer) begin
            oByte      <= '0;
            oValid     <= 1'b0;
            oFrameDone <= 1'b1;
            state      <= IDLE;
          end
        end

        default: begin
          oByte  <= '0;
          oValid <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_str_serializer.sv
// ---------------------------------------------------------------------------
// tb_str_serializer
//
// Directed bench for str_serializer. Instance dut1 uses the default
// parameters (blank zeros, CR/LF); instance dut2 sends every character with
// no terminator. The observed* signals select which instance is checked.
// ---------------------------------------------------------------------------
module tb_str_serializer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] str;
  logic        load1;
  logic        load2;
  logic        ready;

  logic [7:0]  byte1, byte2;
  logic        valid1, valid2;
  logic        busy1, busy2;
  logic        done1, done2;
  logic        drop1, drop2;

  logic        sel;
  logic [7:0]  obsByte;
  logic        obsValid, obsBusy, obsDone, obsDrop;

  int compares = 0;
  int fails    = 0;

  // Expected frame and stimulus controls used by runFrame.
  logic [7:0]  expBuf [8];
  int          expLen;
  bit          rdyPat [16];
  int          rdyLen;
  int          dropStep;
  logic [31:0] dropStr;
  int          expDrops;

  always #5 clock = ~clock;

  str_serializer #(.pChars(4), .pBlankZeros(1'b1), .pAppendCRLF(1'b1)) dut1 (
    .iClock(clock), .iReset_n(reset_n), .iString(str), .iLoad(load1),
    .oByte(byte1), .oValid(valid1), .iReady(ready), .oBusy(busy1),
    .oFrameDone(done1), .oDropped(drop1)
  );

  str_serializer #(.pChars(4), .pBlankZeros(1'b0), .pAppendCRLF(1'b0)) dut2 (
    .iClock(clock), .iReset_n(reset_n), .iString(str), .iLoad(load2),
    .oByte(byte2), .oValid(valid2), .iReady(ready), .oBusy(busy2),
    .oFrameDone(done2), .oDropped(drop2)
  );

  assign obsByte  = sel ? byte2  : byte1;
  assign obsValid = sel ? valid2 : valid1;
  assign obsBusy  = sel ? busy2  : busy1;
  assign obsDone  = sel ? done2  : done1;
  assign obsDrop  = sel ? drop2  : drop1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compares++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Pulse the load of the selected instance at the current negedge; returns
  // at the negedge of the first output cycle.
  task automatic applyStimulus(input logic [31:0] s);
    str = s;
    if (sel) load2 = 1'b1;
    else     load1 = 1'b1;
    @(negedge clock);
    load1 = 1'b0;
    load2 = 1'b0;
  endtask

  task automatic setExp(input logic [63:0] packedBytes, input int n);
    expLen = n;
    for (int i = 0; i < n; i++) begin
      expBuf[i] = packedBytes[8*(n-1-i) +: 8];
    end
  endtask

  // Walks one frame: checks the held byte every cycle (so stalls also prove
  // stability), applies the ready pattern, optionally injects a load while
  // busy, then checks the frame-done cycle.
  task automatic runFrame(input string name);
    int idx   = 0;
    int cyc   = 0;
    int drops = 0;
    bit r;
    while (idx < expLen && cyc < 40) begin
      checkOutput({name, " valid"}, 32'(obsValid), 32'd1);
      checkOutput({name, " busy"},  32'(obsBusy),  32'd1);
      checkOutput({name, " byte"},  32'(obsByte),  32'(expBuf[idx]));
      checkOutput({name, " done early"}, 32'(obsDone), 32'd0);
      r = (cyc < rdyLen) ? rdyPat[cyc] : 1'b1;
      ready = r;
      if (cyc == dropStep) begin
        str   = dropStr;
        load1 = 1'b1;
      end else begin
        load1 = 1'b0;
      end
      @(negedge clock);
      drops += int'(obsDrop);
      if (r) idx++;
      cyc++;
    end
    load1 = 1'b0;
    ready = 1'b1;
    checkOutput({name, " byte count"}, 32'(idx), 32'(expLen));
    checkOutput({name, " frame done"}, 32'(obsDone), 32'd1);
    checkOutput({name, " valid end"},  32'(obsValid), 32'd0);
    checkOutput({name, " busy end"},   32'(obsBusy),  32'd0);
    checkOutput({name, " drops"},      32'(drops),    32'(expDrops));
  endtask

  initial begin
    reset_n  = 1'b0;
    str      = '0;
    load1    = 1'b0;
    load2    = 1'b0;
    ready    = 1'b0;
    sel      = 1'b0;
    rdyLen   = 0;
    dropStep = -1;
    dropStr  = '0;
    expDrops = 0;
    expLen   = 0;

    // Reset state of both instances.
    #12;
    checkOutput("rst byte1",  32'(byte1),  32'd0);
    checkOutput("rst valid1", 32'(valid1), 32'd0);
    checkOutput("rst busy1",  32'(busy1),  32'd0);
    checkOutput("rst done1",  32'(done1),  32'd0);
    checkOutput("rst drop1",  32'(drop1),  32'd0);
    checkOutput("rst valid2", 32'(valid2), 32'd0);
    checkOutput("rst byte2",  32'(byte2),  32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    ready   = 1'b1;
    @(negedge clock);

    // "0042" with blanking and CR/LF.
    setExp(64'h3432_0D0A, 4);
    applyStimulus(32'h30303432);
    runFrame("t1");

    // All zeros: only the least significant '0' is sent.
    @(negedge clock);
    setExp(64'h30_0D0A, 3);
    applyStimulus(32'h30303030);
    runFrame("t2");
    @(negedge clock);
    checkOutput("t2 idle valid", 32'(obsValid), 32'd0);
    checkOutput("t2 idle done",  32'(obsDone),  32'd0);

    // Backpressure pattern.
    setExp(64'h3132_3334_0D0A, 6);
    rdyLen = 8;
    rdyPat[0] = 1'b0; rdyPat[1] = 1'b0; rdyPat[2] = 1'b1; rdyPat[3] = 1'b1;
    rdyPat[4] = 1'b0; rdyPat[5] = 1'b1; rdyPat[6] = 1'b1; rdyPat[7] = 1'b1;
    applyStimulus(32'h31323334);
    runFrame("t3");
    rdyLen = 0;

    // Load while busy is dropped; load in the frame-done cycle is accepted.
    @(negedge clock);
    dropStep = 1;
    dropStr  = 32'h39393939;
    expDrops = 1;
    applyStimulus(32'h31323334);
    runFrame("t4a");
    dropStep = -1;
    expDrops = 0;
    setExp(64'h3536_3738_0D0A, 6);
    applyStimulus(32'h35363738);
    runFrame("t4b");

    // Asynchronous reset during the third byte aborts the frame.
    @(negedge clock);
    applyStimulus(32'h31323334);
    checkOutput("t5 byte0", 32'(obsByte), 32'h31);
    @(negedge clock);
    checkOutput("t5 byte1", 32'(obsByte), 32'h32);
    @(negedge clock);
    checkOutput("t5 byte2", 32'(obsByte), 32'h33);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t5 rst valid", 32'(obsValid), 32'd0);
    checkOutput("t5 rst busy",  32'(obsBusy),  32'd0);
    checkOutput("t5 rst byte",  32'(obsByte),  32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    checkOutput("t5 no done a", 32'(obsDone), 32'd0);
    @(negedge clock);
    checkOutput("t5 no done b",  32'(obsDone),  32'd0);
    checkOutput("t5 idle valid", 32'(obsValid), 32'd0);
    setExp(64'h3132_3334_0D0A, 6);
    applyStimulus(32'h31323334);
    runFrame("t5");

    // No blanking, no terminator.
    @(negedge clock);
    sel = 1'b1;
    setExp(64'h3030_3037, 4);
    applyStimulus(32'h30303037);
    runFrame("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
